// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// pipeline writeback and a long-latency unit whose results are held in a
// small circular FIFO until the port is free.
//
// Optional build macro: WB_ARB_BYPASS_EN
//   defined   -> an lu result arriving while the FIFO is empty and the port
//                is free is written to the RF in its handshake cycle.
//   undefined -> every lu result is enqueued and written at the earliest
//                one cycle after its handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | FIFO empty, pipeline owns the port
// ST_WAIT  | FIFO non-empty, head drains when the pipeline is idle,
//          | age counter running down while the head is not popped
// ST_FORCE | head has starved; head owns the port, pipeline stalled
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_addr_i,
  input  logic [XLEN-1:0] lu_data_i,
  output logic            lu_ready_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_addr_o,
  output logic [XLEN-1:0] rf_data_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            hazard_o,
  output logic            wb_stall_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [AGE_W-1:0] AGE_LOAD = AGE_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

  state_t            state;
  logic [AGE_W-1:0]  age_cnt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [4:0]        addr_mem [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_mem;
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  kill_mask;

  logic fifo_empty;
  logic head_valid;
  logic pipe_wr;
  logic pipe_win;
  logic pop;
  logic lu_fire;
  logic bypass;
  logic push;
  logic hazard_any;

  assign fifo_empty = (count == '0);
  assign head_valid = valid_mem[rd_ptr];
  assign pipe_wr    = wb_en_i && !flush_i && (wb_addr_i != 5'd0);
  // In FORCE the head owns the port even if the pipeline misbehaves.
  assign pipe_win   = pipe_wr && (state != ST_FORCE);
  // A killed head still pops, it just produces no RF write.
  assign pop        = !fifo_empty && !pipe_win;
  // Ready is forced high while in reset so the interface looks empty at once.
  assign lu_ready_o = rst_i || (count < CNT_FULL);
  assign lu_fire    = lu_valid_i && lu_ready_o && !rst_i;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = lu_fire && fifo_empty && !pipe_win && (lu_addr_i != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results complete the handshake but are never stored.
  assign push       = lu_fire && (lu_addr_i != 5'd0) && !bypass;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // WAW kill mask and next valid vector for the buffered entries
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_mask[i] = valid_mem[i] && pipe_win && (addr_mem[i] == wb_addr_i);
    end
    valid_next = valid_mem & ~kill_mask;
    if (pop)  valid_next[rd_ptr] = 1'b0;
    if (push) valid_next[wr_ptr] = 1'b1;
  end

  // register-file write port mux; silenced during reset so nothing buffered leaks out
  always_comb begin
    rf_we_o   = 1'b0;
    rf_addr_o = 5'd0;
    rf_data_o = '0;
    if (!rst_i) begin
      if (pop && head_valid) begin
        rf_we_o   = 1'b1;
        rf_addr_o = addr_mem[rd_ptr];
        rf_data_o = data_mem[rd_ptr];
      end else if (pipe_win) begin
        rf_we_o   = 1'b1;
        rf_addr_o = wb_addr_i;
        rf_data_o = wb_data_i;
      end else if (bypass) begin
        rf_we_o   = 1'b1;
        rf_addr_o = lu_addr_i;
        rf_data_o = lu_data_i;
      end
    end
  end

  // RAW hazard against any still-valid buffered destination
  always_comb begin
    hazard_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_mem[i] &&
          (((rs1_addr_i != 5'd0) && (addr_mem[i] == rs1_addr_i)) ||
           ((rs2_addr_i != 5'd0) && (addr_mem[i] == rs2_addr_i)))) begin
        hazard_any = 1'b1;
      end
    end
    hazard_o = hazard_any && !rst_i;
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      valid_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= 5'd0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= lu_addr_i;
        data_mem[wr_ptr] <= lu_data_i;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      valid_mem <= valid_next;
    end
  end

  // arbitration FSM with starvation down-counter and registered stall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      age_cnt    <= AGE_LOAD;
      wb_stall_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wb_stall_o <= 1'b0;
          age_cnt    <= AGE_LOAD;
          if (push) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pop) begin
            age_cnt <= AGE_LOAD;
            state   <= (count_next == '0) ? ST_IDLE : ST_WAIT;
          end else if (age_cnt <= AGE_W'(1)) begin
            // terminal count: head has gone STARVE_MAX-1 cycles unserved
            state      <= ST_FORCE;
            wb_stall_o <= 1'b1;
          end else begin
            age_cnt <= age_cnt - AGE_W'(1);
          end
        end
        ST_FORCE: begin
          age_cnt    <= AGE_LOAD;
          wb_stall_o <= 1'b0;
          state      <= (count_next == '0) ? ST_IDLE : ST_WAIT;
        end
        default: begin
          state      <= ST_IDLE;
          age_cnt    <= AGE_LOAD;
          wb_stall_o <= 1'b0;
        end
      endcase
    end
  end

  // the pipeline must hold its writeback while stalled
  a_no_wb_in_force: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wb_en_i && (state == ST_FORCE)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter at default parameters
// (XLEN=32, DEPTH=2, STARVE_MAX=4). Honours WB_ARB_BYPASS_EN when defined.
module tb_wb_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        lu_valid_i;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        hazard_o;
  logic        wb_stall_o;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .flush_i    (flush_i),
    .lu_valid_i (lu_valid_i),
    .lu_addr_i  (lu_addr_i),
    .lu_data_i  (lu_data_i),
    .lu_ready_o (lu_ready_o),
    .rf_we_o    (rf_we_o),
    .rf_addr_o  (rf_addr_o),
    .rf_data_o  (rf_data_o),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .hazard_o   (hazard_o),
    .wb_stall_o (wb_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    wb_en_i    = 1'b0;
    wb_addr_i  = 5'd0;
    wb_data_i  = 32'd0;
    flush_i    = 1'b0;
    lu_valid_i = 1'b0;
    lu_addr_i  = 5'd0;
    lu_data_i  = 32'd0;
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    wb_en_i   = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid_i = 1'b1;
    lu_addr_i  = a;
    lu_data_i  = d;
  endtask

  // inputs change 1 time unit after the rising edge; outputs sampled on the falling edge
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check_val({tag, "_we"}, {31'd0, rf_we_o}, {31'd0, we});
    if (we) begin
      check_val({tag, "_addr"}, {27'd0, rf_addr_o}, {27'd0, a});
      check_val({tag, "_data"}, rf_data_o, d);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_we"},     {31'd0, rf_we_o},    32'd0);
    check_val({tag, "_addr"},   {27'd0, rf_addr_o},  32'd0);
    check_val({tag, "_data"},   rf_data_o,           32'd0);
    check_val({tag, "_ready"},  {31'd0, lu_ready_o}, 32'd1);
    check_val({tag, "_hazard"}, {31'd0, hazard_o},   32'd0);
    check_val({tag, "_stall"},  {31'd0, wb_stall_o}, 32'd0);
  endtask

  initial begin
    clear_in();
    rst_i = 1'b1;
    next_cyc();
    next_cyc();
    rst_i = 1'b0;
    settle();
    check_reset_outs("rst");
    next_cyc();

    // single lu result x5=0xA5 with the port free
    drive_lu(5'd5, 32'hA5);
    settle();
`ifdef WB_ARB_BYPASS_EN
    check_rf("lat_c0", 1'b1, 5'd5, 32'hA5);
`else
    check_rf("lat_c0", 1'b0, 5'd0, 32'd0);
`endif
    next_cyc();
    clear_in();
    settle();
`ifdef WB_ARB_BYPASS_EN
    check_rf("lat_c1", 1'b0, 5'd0, 32'd0);
`else
    check_rf("lat_c1", 1'b1, 5'd5, 32'hA5);
`endif
    next_cyc();
    settle();
    check_rf("lat_c2", 1'b0, 5'd0, 32'd0);
    next_cyc();

    // fill the two-entry buffer under continuous pipeline writes
    drive_wb(5'd1, 32'h100);
    drive_lu(5'd10, 32'h10);
    settle();
    check_val("full_a_ready", {31'd0, lu_ready_o}, 32'd1);
    check_rf("full_a", 1'b1, 5'd1, 32'h100);
    next_cyc();
    drive_wb(5'd2, 32'h200);
    drive_lu(5'd11, 32'h11);
    settle();
    check_val("full_b_ready", {31'd0, lu_ready_o}, 32'd1);
    next_cyc();
    drive_wb(5'd3, 32'h300);
    drive_lu(5'd12, 32'h12);
    settle();
    check_val("full_c_ready", {31'd0, lu_ready_o}, 32'd0);
    check_rf("full_c", 1'b1, 5'd3, 32'h300);
    next_cyc();
    wb_en_i = 1'b0;
    settle();
    check_val("full_d_ready", {31'd0, lu_ready_o}, 32'd0);
    check_rf("full_d", 1'b1, 5'd10, 32'h10);
    next_cyc();
    settle();
    check_val("full_e_ready", {31'd0, lu_ready_o}, 32'd1);
    check_rf("full_e", 1'b1, 5'd11, 32'h11);
    next_cyc();
    clear_in();
    settle();
    check_rf("full_f", 1'b1, 5'd12, 32'h12);
    next_cyc();
    settle();
    check_rf("full_g", 1'b0, 5'd0, 32'd0);
    next_cyc();

    // starvation: x7 buffered while the pipeline keeps the port busy
    drive_wb(5'd1, 32'h1);
    drive_lu(5'd7, 32'h77);
    next_cyc();
    lu_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      drive_wb(5'(c + 1), 32'(c + 1));
      settle();
      check_val($sformatf("starve_c%0d_stall", c), {31'd0, wb_stall_o}, 32'd0);
      check_rf($sformatf("starve_c%0d", c), 1'b1, 5'(c + 1), 32'(c + 1));
      next_cyc();
    end
    clear_in();
    settle();
    check_val("starve_c4_stall", {31'd0, wb_stall_o}, 32'd1);
    check_rf("starve_c4", 1'b1, 5'd7, 32'h77);
    next_cyc();
    settle();
    check_val("starve_c5_stall", {31'd0, wb_stall_o}, 32'd0);
    check_rf("starve_c5", 1'b0, 5'd0, 32'd0);
    next_cyc();

    // WAW kill: buffered x9=1 overtaken by pipeline x9=2
    drive_wb(5'd1, 32'h11);
    drive_lu(5'd9, 32'h1);
    next_cyc();
    clear_in();
    drive_wb(5'd9, 32'h2);
    rs1_addr_i = 5'd9;
    settle();
    check_val("waw_c1_hazard", {31'd0, hazard_o}, 32'd1);
    check_rf("waw_c1", 1'b1, 5'd9, 32'h2);
    next_cyc();
    wb_en_i = 1'b0;
    settle();
    check_val("waw_c2_hazard", {31'd0, hazard_o}, 32'd0);
    check_rf("waw_c2", 1'b0, 5'd0, 32'd0);
    next_cyc();
    clear_in();
    settle();
    check_rf("waw_c3", 1'b0, 5'd0, 32'd0);
    next_cyc();

    // x0 lu result: handshakes, never stored, never written
    drive_lu(5'd0, 32'hDEAD);
    settle();
    check_val("x0_ready", {31'd0, lu_ready_o}, 32'd1);
    check_val("x0_hazard", {31'd0, hazard_o}, 32'd0);
    check_rf("x0_c0", 1'b0, 5'd0, 32'd0);
    next_cyc();
    clear_in();
    settle();
    check_val("x0_c1_hazard", {31'd0, hazard_o}, 32'd0);
    check_rf("x0_c1", 1'b0, 5'd0, 32'd0);
    next_cyc();

    // flushed pipeline write does not claim the port
    drive_wb(5'd3, 32'h333);
    flush_i = 1'b1;
    drive_lu(5'd4, 32'h44);
    settle();
`ifdef WB_ARB_BYPASS_EN
    check_rf("flush_c0", 1'b1, 5'd4, 32'h44);
`else
    check_rf("flush_c0", 1'b0, 5'd0, 32'd0);
`endif
    next_cyc();
    clear_in();
    settle();
`ifdef WB_ARB_BYPASS_EN
    check_rf("flush_c1", 1'b0, 5'd0, 32'd0);
`else
    check_rf("flush_c1", 1'b1, 5'd4, 32'h44);
`endif
    next_cyc();

    // reset with two entries buffered
    drive_wb(5'd1, 32'h1);
    drive_lu(5'd20, 32'h20);
    next_cyc();
    drive_wb(5'd2, 32'h2);
    drive_lu(5'd21, 32'h21);
    rs2_addr_i = 5'd20;
    settle();
    check_val("rst2_pre_hazard", {31'd0, hazard_o}, 32'd1);
    check_val("rst2_pre_ready", {31'd0, lu_ready_o}, 32'd1);
    next_cyc();
    clear_in();
    rs2_addr_i = 5'd20;
    rst_i = 1'b1;
    settle();
    check_rf("rst2_during", 1'b0, 5'd0, 32'd0);
    check_val("rst2_during_hazard", {31'd0, hazard_o}, 32'd0);
    check_val("rst2_during_ready", {31'd0, lu_ready_o}, 32'd1);
    next_cyc();
    rst_i = 1'b0;
    settle();
    check_reset_outs("rst2_after");
    next_cyc();
    settle();
    check_rf("rst2_c4", 1'b0, 5'd0, 32'd0);
    check_val("rst2_c4_hazard", {31'd0, hazard_o}, 32'd0);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
